// File: rtl/mem_bus_arbiter.sv
// Two-requester memory bus arbiter: fetch and load/store ports share one
// waitrequest-style bus, with round-robin tie-break and registered bus outputs.
module mem_bus_arbiter #(
    parameter logic [3:0] FETCH_BYTEENABLE = 4'b1111
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        f_req,
    input  logic [31:0] f_addr,
    output logic [31:0] f_rdata,
    output logic        f_done,

    input  logic        d_req,
    input  logic        d_write,
    input  logic [31:0] d_addr,
    input  logic [3:0]  d_byteenable,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_done,

    output logic        busy,

    output logic [31:0] address,
    output logic        read,
    output logic        write,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    input  logic [31:0] readdata,
    input  logic        waitrequest
);

    typedef enum logic [1:0] {StIdle, StBusF, StBusD, StResp} state_e;

    localparam logic GrantF = 1'b0;
    localparam logic GrantD = 1'b1;

    state_e      state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic [31:0] address_q, address_d;
    logic        read_q, read_d;
    logic        write_q, write_d;
    logic [31:0] writedata_q, writedata_d;
    logic [3:0]  byteenable_q, byteenable_d;
    logic [31:0] f_rdata_q, f_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic        f_done_q, f_done_d;
    logic        d_done_q, d_done_d;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        address_d    = address_q;
        read_d       = read_q;
        write_d      = write_q;
        writedata_d  = writedata_q;
        byteenable_d = byteenable_q;
        f_rdata_d    = f_rdata_q;
        d_rdata_d    = d_rdata_q;
        f_done_d     = 1'b0;
        d_done_d     = 1'b0;

        unique case (state_q)
            StIdle: begin
                // On a tie, fetch wins unless it was the most recent grant.
                if (f_req && (!d_req || last_grant_q == GrantD)) begin
                    state_d      = StBusF;
                    read_d       = 1'b1;
                    write_d      = 1'b0;
                    address_d    = {f_addr[31:2], 2'b00};
                    byteenable_d = FETCH_BYTEENABLE;
                    writedata_d  = 32'h0;
                end else if (d_req) begin
                    state_d      = StBusD;
                    read_d       = !d_write;
                    write_d      = d_write;
                    address_d    = {d_addr[31:2], 2'b00};
                    byteenable_d = d_byteenable;
                    writedata_d  = d_wdata;
                end
            end
            StBusF: begin
                if (!waitrequest) begin
                    state_d      = StResp;
                    f_rdata_d    = readdata;
                    last_grant_d = GrantF;
                    f_done_d     = 1'b1;
                    read_d       = 1'b0;
                    write_d      = 1'b0;
                end
            end
            StBusD: begin
                if (!waitrequest) begin
                    state_d      = StResp;
                    if (!write_q) begin
                        d_rdata_d = readdata;
                    end
                    last_grant_d = GrantD;
                    d_done_d     = 1'b1;
                    read_d       = 1'b0;
                    write_d      = 1'b0;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            last_grant_q <= GrantD;
            address_q    <= 32'h0;
            read_q       <= 1'b0;
            write_q      <= 1'b0;
            writedata_q  <= 32'h0;
            byteenable_q <= 4'h0;
            f_rdata_q    <= 32'h0;
            d_rdata_q    <= 32'h0;
            f_done_q     <= 1'b0;
            d_done_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            address_q    <= address_d;
            read_q       <= read_d;
            write_q      <= write_d;
            writedata_q  <= writedata_d;
            byteenable_q <= byteenable_d;
            f_rdata_q    <= f_rdata_d;
            d_rdata_q    <= d_rdata_d;
            f_done_q     <= f_done_d;
            d_done_q     <= d_done_d;
        end
    end

    assign address    = address_q;
    assign read       = read_q;
    assign write      = write_q;
    assign writedata  = writedata_q;
    assign byteenable = byteenable_q;
    assign f_rdata    = f_rdata_q;
    assign d_rdata    = d_rdata_q;
    assign f_done     = f_done_q;
    assign d_done     = d_done_q;
    assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter; completions are checked against a
// scoreboard of expected requester, read data and latency.
module tb_mem_bus_arbiter;

    logic        clk;
    logic        reset;
    logic        f_req;
    logic [31:0] f_addr;
    logic [31:0] f_rdata;
    logic        f_done;
    logic        d_req;
    logic        d_write;
    logic [31:0] d_addr;
    logic [3:0]  d_byteenable;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_done;
    logic        busy;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] readdata;
    logic        waitrequest;

    int n_asserts = 0;
    int n_fails   = 0;

    typedef struct {
        logic        is_f;
        logic [31:0] data;
        int          lat;
    } exp_t;

    exp_t sb[$];

    mem_bus_arbiter #(
        .FETCH_BYTEENABLE(4'b1111)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .f_req        (f_req),
        .f_addr       (f_addr),
        .f_rdata      (f_rdata),
        .f_done       (f_done),
        .d_req        (d_req),
        .d_write      (d_write),
        .d_addr       (d_addr),
        .d_byteenable (d_byteenable),
        .d_wdata      (d_wdata),
        .d_rdata      (d_rdata),
        .d_done       (d_done),
        .busy         (busy),
        .address      (address),
        .read         (read),
        .write        (write),
        .writedata    (writedata),
        .byteenable   (byteenable),
        .readdata     (readdata),
        .waitrequest  (waitrequest)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic is_f, input logic [31:0] data, input int lat);
        exp_t e;
        e.is_f = is_f;
        e.data = data;
        e.lat  = lat;
        sb.push_back(e);
    endtask

    // Step until a done pulse (bounded), then compare against the scoreboard head.
    task automatic collect();
        exp_t e;
        int   n;
        n = 0;
        check("sb_nonempty", {31'h0, sb.size() != 0}, 32'h1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            do begin
                step();
                n++;
            end while (!(f_done || d_done) && n < 20);
            check("done_latency", n, e.lat);
            check("done_which", {30'h0, f_done, d_done}, e.is_f ? 32'h2 : 32'h1);
            check("done_rdata", e.is_f ? f_rdata : d_rdata, e.data);
        end
    endtask

    always @(negedge clk) begin
        n_asserts++;
        assert (!(read && write)) else begin
            n_fails++;
            $error("FAIL rw_excl: observed read=%b write=%b expected not both", read, write);
        end
    end

    initial begin
        reset        = 1'b1;
        f_req        = 1'b0;
        f_addr       = 32'h0;
        d_req        = 1'b0;
        d_write      = 1'b0;
        d_addr       = 32'h0;
        d_byteenable = 4'h0;
        d_wdata      = 32'h0;
        readdata     = 32'h0;
        waitrequest  = 1'b0;
        step();
        step();
        check("rst_read", {31'h0, read}, 32'h0);
        check("rst_write", {31'h0, write}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_address", address, 32'h0);
        check("rst_be", {28'h0, byteenable}, 32'h0);
        check("rst_wdata", writedata, 32'h0);
        check("rst_frdata", f_rdata, 32'h0);
        check("rst_drdata", d_rdata, 32'h0);
        check("rst_done", {30'h0, f_done, d_done}, 32'h0);
        reset = 1'b0;
        step();

        // Single fetch, no wait states.
        f_req    = 1'b1;
        f_addr   = 32'hBFC0_0002;
        readdata = 32'h2402_0005;
        push(1'b1, 32'h2402_0005, 1);
        step();
        check("f_read", {31'h0, read}, 32'h1);
        check("f_write", {31'h0, write}, 32'h0);
        check("f_address", address, 32'hBFC0_0000);
        check("f_be", {28'h0, byteenable}, 32'hF);
        check("f_wdata", writedata, 32'h0);
        check("f_busy", {31'h0, busy}, 32'h1);
        collect();
        check("f_resp_read", {31'h0, read}, 32'h0);
        f_req = 1'b0;
        step();
        check("f_done_pulse", {31'h0, f_done}, 32'h0);
        check("f_idle_busy", {31'h0, busy}, 32'h0);

        // Store with three wait-state cycles; readdata must not be captured.
        d_req        = 1'b1;
        d_write      = 1'b1;
        d_addr       = 32'h0000_1004;
        d_byteenable = 4'b0011;
        d_wdata      = 32'hDEAD_BEEF;
        readdata     = 32'hCAFE_F00D;
        waitrequest  = 1'b1;
        push(1'b0, 32'h0, 1);
        for (int i = 0; i < 4; i++) begin
            step();
            check("st_write", {31'h0, write}, 32'h1);
            check("st_read", {31'h0, read}, 32'h0);
            check("st_address", address, 32'h0000_1004);
            check("st_be", {28'h0, byteenable}, 32'h3);
            check("st_wdata", writedata, 32'hDEAD_BEEF);
            check("st_no_done", {31'h0, d_done}, 32'h0);
            if (i == 3) waitrequest = 1'b0;
        end
        collect();
        d_req = 1'b0;
        step();
        check("st_done_pulse", {31'h0, d_done}, 32'h0);

        // Reset while a load is stalled on the bus.
        d_req       = 1'b1;
        d_write     = 1'b0;
        d_addr      = 32'h0000_2000;
        d_byteenable = 4'hF;
        waitrequest = 1'b1;
        readdata    = 32'h5555_AAAA;
        step();
        check("ld_read", {31'h0, read}, 32'h1);
        reset = 1'b1;
        step();
        check("rst_mid_read", {31'h0, read}, 32'h0);
        check("rst_mid_write", {31'h0, write}, 32'h0);
        check("rst_mid_busy", {31'h0, busy}, 32'h0);
        check("rst_mid_done", {31'h0, d_done}, 32'h0);
        reset       = 1'b0;
        d_req       = 1'b0;
        waitrequest = 1'b0;
        step();
        check("rst_mid_no_done", {31'h0, d_done}, 32'h0);
        check("rst_mid_drdata", d_rdata, 32'h0);

        // Both requesting continuously: F first after reset, then alternate.
        f_req   = 1'b1;
        f_addr  = 32'h0000_0100;
        d_req   = 1'b1;
        d_write = 1'b0;
        d_addr  = 32'h0000_0200;
        for (int k = 0; k < 4; k++) begin
            readdata = 32'h1000_0000 + k;
            push((k % 2) == 0, 32'h1000_0000 + k, 2);
            collect();
            step();
            check("rr_idle", {31'h0, busy}, 32'h0);
        end
        f_req = 1'b0;
        d_req = 1'b0;
        step();

        // Load then fetch: the load result must survive the fetch.
        d_req    = 1'b1;
        d_write  = 1'b0;
        readdata = 32'h1234_5678;
        push(1'b0, 32'h1234_5678, 2);
        collect();
        d_req = 1'b0;
        step();
        f_req    = 1'b1;
        readdata = 32'hAAAA_5555;
        push(1'b1, 32'hAAAA_5555, 2);
        collect();
        f_req = 1'b0;
        check("d_rdata_hold", d_rdata, 32'h1234_5678);
        step();

        // Fetch request dropped mid-flight still completes.
        f_req       = 1'b1;
        f_addr      = 32'h0000_0040;
        waitrequest = 1'b1;
        readdata    = 32'h0BAD_F00D;
        step();
        f_req = 1'b0;
        step();
        check("abort_busy", {31'h0, busy}, 32'h1);
        waitrequest = 1'b0;
        push(1'b1, 32'h0BAD_F00D, 1);
        collect();
        step();

        check("sb_empty", sb.size(), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
